// File: rtl/lda_pkg.sv
// Shared types and default widths for the Bresenham line-drawing engine.
package lda_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } lda_state_t;

  localparam int LDA_X_W     = 9;
  localparam int LDA_Y_W     = 8;
  localparam int LDA_COLOR_W = 3;

endpackage

// File: rtl/lda_draw_engine_if.sv
// Command and pixel-plot bundle between the register block, the draw engine
// and the framebuffer adapter.
interface lda_draw_engine_if
  import lda_pkg::*;
#(
  parameter int X_W     = LDA_X_W,
  parameter int Y_W     = LDA_Y_W,
  parameter int COLOR_W = LDA_COLOR_W
);

  logic               i_start;
  logic [X_W-1:0]     i_x0;
  logic [X_W-1:0]     i_x1;
  logic [Y_W-1:0]     i_y0;
  logic [Y_W-1:0]     i_y1;
  logic [COLOR_W-1:0] i_color;
  logic               i_plot_ready;
  logic               o_plot;
  logic [X_W-1:0]     o_x;
  logic [Y_W-1:0]     o_y;
  logic [COLOR_W-1:0] o_color;
  logic               o_busy;
  logic               o_done;

  // The engine side.
  modport slave (
    input  i_start, i_x0, i_x1, i_y0, i_y1, i_color, i_plot_ready,
    output o_plot, o_x, o_y, o_color, o_busy, o_done
  );

  // The register block / adapter side.
  modport master (
    output i_start, i_x0, i_x1, i_y0, i_y1, i_color, i_plot_ready,
    input  o_plot, o_x, o_y, o_color, o_busy, o_done
  );

endinterface

// File: rtl/lda_draw_engine.sv
// Bresenham line engine: one command in, a stream of single-pixel writes out,
// with every output registered and held while the adapter stalls.
module lda_draw_engine
  import lda_pkg::*;
#(
  parameter int X_W     = LDA_X_W,
  parameter int Y_W     = LDA_Y_W,
  parameter int COLOR_W = LDA_COLOR_W
) (
  input  logic              clk,
  input  logic              reset,
  lda_draw_engine_if.slave  bus
);

  localparam int C_W = (X_W > Y_W) ? X_W : Y_W;
  localparam int W   = C_W + 2;
  localparam logic signed [W-1:0] ONE = W'(1);

  function automatic logic signed [W-1:0] ext_x(input logic [X_W-1:0] v);
    logic signed [W-1:0] r;
    r          = '0;
    r[X_W-1:0] = v;
    return r;
  endfunction

  function automatic logic signed [W-1:0] ext_y(input logic [Y_W-1:0] v);
    logic signed [W-1:0] r;
    r          = '0;
    r[Y_W-1:0] = v;
    return r;
  endfunction

  function automatic logic signed [W-1:0] sabs(input logic signed [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  // Control and output registers (reset).
  lda_state_t         state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               plot_q, plot_d;
  logic [X_W-1:0]     ox_q, ox_d;
  logic [Y_W-1:0]     oy_q, oy_d;
  logic [COLOR_W-1:0] ocol_q, ocol_d;

  // Datapath registers (no reset; always loaded before use).
  logic [X_W-1:0]      lx0_q, lx0_d, lx1_q, lx1_d;
  logic [Y_W-1:0]      ly0_q, ly0_d, ly1_q, ly1_d;
  logic [COLOR_W-1:0]  lcol_q, lcol_d;
  logic                steep_q, steep_d;
  logic                yneg_q, yneg_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d, xe_q, xe_d;
  logic signed [W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;

  // Setup temporaries.
  logic signed [W-1:0] ax0, ax1, ay0, ay1, adx, ady;
  logic signed [W-1:0] sx0, sx1, sy0, sy1;
  logic signed [W-1:0] fx0, fx1, fy0, fy1, dxs, err_n;
  logic                steep_c, swap_c;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    plot_d  = plot_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    ocol_d  = ocol_q;
    lx0_d   = lx0_q;
    lx1_d   = lx1_q;
    ly0_d   = ly0_q;
    ly1_d   = ly1_q;
    lcol_d  = lcol_q;
    steep_d = steep_q;
    yneg_d  = yneg_q;
    x_d     = x_q;
    y_d     = y_q;
    xe_d    = xe_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;

    // Octant normalisation: make the line shallow, then left-to-right.
    ax0     = ext_x(lx0_q);
    ax1     = ext_x(lx1_q);
    ay0     = ext_y(ly0_q);
    ay1     = ext_y(ly1_q);
    adx     = sabs(ax1 - ax0);
    ady     = sabs(ay1 - ay0);
    steep_c = ady > adx;
    sx0     = steep_c ? ay0 : ax0;
    sx1     = steep_c ? ay1 : ax1;
    sy0     = steep_c ? ax0 : ay0;
    sy1     = steep_c ? ax1 : ay1;
    swap_c  = sx0 > sx1;
    fx0     = swap_c ? sx1 : sx0;
    fx1     = swap_c ? sx0 : sx1;
    fy0     = swap_c ? sy1 : sy0;
    fy1     = swap_c ? sy0 : sy1;
    dxs     = fx1 - fx0;
    err_n   = err_q + dy_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.i_start) begin
          lx0_d   = bus.i_x0;
          lx1_d   = bus.i_x1;
          ly0_d   = bus.i_y0;
          ly1_d   = bus.i_y1;
          lcol_d  = bus.i_color;
          busy_d  = 1'b1;
          state_d = INIT;
        end
      end
      INIT: begin
        steep_d = steep_c;
        x_d     = fx0;
        y_d     = fy0;
        xe_d    = fx1;
        dx_d    = dxs;
        dy_d    = sabs(fy1 - fy0);
        err_d   = -(dxs >>> 1);
        yneg_d  = !(fy0 < fy1);
        plot_d  = 1'b1;
        ox_d    = steep_c ? fy0[X_W-1:0] : fx0[X_W-1:0];
        oy_d    = steep_c ? fx0[Y_W-1:0] : fy0[Y_W-1:0];
        ocol_d  = lcol_q;
        state_d = DRAW;
      end
      DRAW: begin
        if (bus.i_plot_ready) begin
          if (x_q == xe_q) begin
            plot_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            x_d = x_q + ONE;
            if (!err_n[W-1]) begin
              y_d   = yneg_q ? (y_q - ONE) : (y_q + ONE);
              err_d = err_n - dx_q;
            end else begin
              err_d = err_n;
            end
            ox_d = steep_q ? y_d[X_W-1:0] : x_d[X_W-1:0];
            oy_d = steep_q ? x_d[Y_W-1:0] : y_d[Y_W-1:0];
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        plot_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      plot_q  <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      ocol_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      plot_q  <= plot_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      ocol_q  <= ocol_d;
    end
  end

  always_ff @(posedge clk) begin
    lx0_q   <= lx0_d;
    lx1_q   <= lx1_d;
    ly0_q   <= ly0_d;
    ly1_q   <= ly1_d;
    lcol_q  <= lcol_d;
    steep_q <= steep_d;
    yneg_q  <= yneg_d;
    x_q     <= x_d;
    y_q     <= y_d;
    xe_q    <= xe_d;
    dx_q    <= dx_d;
    dy_q    <= dy_d;
    err_q   <= err_d;
  end

  assign bus.o_plot  = plot_q;
  assign bus.o_x     = ox_q;
  assign bus.o_y     = oy_q;
  assign bus.o_color = ocol_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

endmodule

// File: tb/tb_lda_draw_engine.sv
// Scoreboard bench for lda_draw_engine: directed octant/stall/reset cases plus
// random lines against an integer Bresenham reference.
module tb_lda_draw_engine;
  import lda_pkg::*;

  localparam int X_W = LDA_X_W;
  localparam int Y_W = LDA_Y_W;
  localparam int CW  = LDA_COLOR_W;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  lda_draw_engine_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(CW)) bus ();

  lda_draw_engine #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pix_t exp_q[$];
  int   start_q[$];
  int   pending       = 0;
  int   done_cnt      = 0;
  int   last_done_cyc = 0;
  int   last_acc      = 0;
  int   compared      = 0;
  int   mismatched    = 0;
  int   rdy_mode      = 0;
  logic hold_v        = 1'b0;
  int   hold_x        = 0;
  int   hold_y        = 0;
  logic idle_chk      = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: textbook integer Bresenham producing the full pixel list.
  function automatic void model(input int ax0, input int ay0, input int ax1,
                                input int ay1, input int c);
    int x0 = ax0;
    int y0 = ay0;
    int x1 = ax1;
    int y1 = ay1;
    int t, dx, dy, err, ys, y;
    bit steep;
    pix_t p;
    steep = iabs(y1 - y0) > iabs(x1 - x0);
    if (steep) begin
      t = x0; x0 = y0; y0 = t;
      t = x1; x1 = y1; y1 = t;
    end
    if (x0 > x1) begin
      t = x0; x0 = x1; x1 = t;
      t = y0; y0 = y1; y1 = t;
    end
    dx  = x1 - x0;
    dy  = iabs(y1 - y0);
    err = -(dx / 2);
    ys  = (y0 < y1) ? 1 : -1;
    y   = y0;
    for (int x = x0; x <= x1; x++) begin
      p.x = steep ? y : x;
      p.y = steep ? x : y;
      p.c = c;
      exp_q.push_back(p);
      err += dy;
      if (err >= 0) begin
        y   += ys;
        err -= dx;
      end
    end
  endfunction

  // Ready generator: 0 = always ready, 1 = random stalls, 2 = driven by the test.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) bus.i_plot_ready = 1'b1;
    else if (rdy_mode == 1) bus.i_plot_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on every accepted pixel and checks timing.
  always @(negedge clk) begin
    if (reset) begin
      hold_v   = 1'b0;
      idle_chk = 1'b0;
    end else begin
      if (idle_chk) begin
        chk("busy_after_done", int'(bus.o_busy), 0);
        idle_chk = 1'b0;
      end
      if (start_q.size() > 0) begin
        if (cyc == start_q[0] + 1) begin
          chk("busy_in_init", int'(bus.o_busy), 1);
          chk("plot_in_init", int'(bus.o_plot), 0);
        end else if (cyc == start_q[0] + 2) begin
          chk("first_pixel_latency", int'(bus.o_plot), 1);
          void'(start_q.pop_front());
        end
      end
      if (bus.o_plot) begin
        if (hold_v) begin
          chk("stall_hold_x", int'(bus.o_x), hold_x);
          chk("stall_hold_y", int'(bus.o_y), hold_y);
        end
        if (bus.i_plot_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pixel", 1, 0);
          end else begin
            pix_t p;
            p = exp_q.pop_front();
            chk("pixel_x", int'(bus.o_x), p.x);
            chk("pixel_y", int'(bus.o_y), p.y);
            chk("pixel_color", int'(bus.o_color), p.c);
          end
          last_acc = cyc;
          hold_v   = 1'b0;
        end else begin
          hold_v = 1'b1;
          hold_x = int'(bus.o_x);
          hold_y = int'(bus.o_y);
        end
      end
      if (bus.o_done) begin
        chk("done_expected", int'(pending > 0), 1);
        chk("done_after_last_pixel", cyc, last_acc + 1);
        chk("busy_in_done", int'(bus.o_busy), 1);
        chk("pixels_left_at_done", exp_q.size(), 0);
        if (pending > 0) pending--;
        done_cnt++;
        last_done_cyc = cyc;
        idle_chk      = 1'b1;
      end
    end
  end

  // Call only at posedge+#1; returns one cycle after the strobe cycle n.
  task automatic issue(input int x0, input int y0, input int x1, input int y1,
                       input int c, output int n);
    int t = 0;
    while (bus.o_busy && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 5000) chk("issue_wait_idle_timeout", 1, 0);
    bus.i_x0    = X_W'(x0);
    bus.i_y0    = Y_W'(y0);
    bus.i_x1    = X_W'(x1);
    bus.i_y1    = Y_W'(y1);
    bus.i_color = CW'(c);
    bus.i_start = 1'b1;
    n = cyc;
    model(x0, y0, x1, y1, c);
    pending++;
    start_q.push_back(cyc);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int prev, output int dc);
    int t = 0;
    while (done_cnt <= prev && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 5000) chk("wait_done_timeout", 1, 0);
    dc = last_done_cyc;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_plot"},  int'(bus.o_plot),  0);
    chk({tag, "_x"},     int'(bus.o_x),     0);
    chk({tag, "_y"},     int'(bus.o_y),     0);
    chk({tag, "_color"}, int'(bus.o_color), 0);
    chk({tag, "_busy"},  int'(bus.o_busy),  0);
    chk({tag, "_done"},  int'(bus.o_done),  0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, dc, prev, saved;
    bus.i_start      = 1'b0;
    bus.i_x0         = '0;
    bus.i_y0         = '0;
    bus.i_x1         = '0;
    bus.i_y1         = '0;
    bus.i_color      = '0;
    bus.i_plot_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset_state");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Horizontal line
    prev = done_cnt;
    issue(0, 0, 3, 0, 1, n);
    wait_done(prev, dc);
    chk("horiz_done_cycle", dc, n + 6);

    // Steep line and reversed octant
    prev = done_cnt;
    issue(0, 0, 1, 3, 2, n);
    wait_done(prev, dc);
    chk("steep_done_cycle", dc, n + 6);
    prev = done_cnt;
    issue(3, 2, 0, 0, 6, n);
    wait_done(prev, dc);
    chk("reversed_done_cycle", dc, n + 6);

    // Single point
    prev = done_cnt;
    issue(5, 5, 5, 5, 5, n);
    wait_done(prev, dc);
    chk("point_done_cycle", dc, n + 3);

    // Backpressure on the 2nd pixel, plus a start strobe while busy
    rdy_mode         = 2;
    bus.i_plot_ready = 1'b1;
    prev = done_cnt;
    issue(0, 0, 3, 0, 4, n);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.i_plot_ready = 1'b0;
    @(posedge clk); #1;
    bus.i_x0    = X_W'(7);
    bus.i_x1    = X_W'(100);
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    bus.i_plot_ready = 1'b1;
    wait_done(prev, dc);
    chk("stall_done_cycle", dc, n + 9);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_start_ignored", int'(bus.o_busy), 0);
    rdy_mode = 0;

    // Reset in the middle of a line
    issue(0, 0, 9, 0, 2, n);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_outputs_zero("mid_reset");
    exp_q.delete();
    start_q.delete();
    pending = 0;
    saved   = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt, saved);
    prev = done_cnt;
    issue(2, 1, 6, 3, 3, n);
    wait_done(prev, dc);
    chk("post_reset_done_cycle", dc, n + 7);

    // Extremes and random lines under random stalls
    rdy_mode = 1;
    issue(319, 239, 0, 0, 7, n);
    issue(0, 239, 319, 0, 1, n);
    for (int i = 0; i < 30; i++) begin
      int x0, y0, x1, y1;
      x0 = $urandom_range(0, 319);
      y0 = $urandom_range(0, 239);
      if (i % 2 == 0) begin
        x1 = $urandom_range(0, 319);
        y1 = $urandom_range(0, 239);
      end else begin
        x1 = x0 + $urandom_range(0, 12) - 6;
        y1 = y0 + $urandom_range(0, 12) - 6;
        if (x1 < 0) x1 = 0;
        if (x1 > 319) x1 = 319;
        if (y1 < 0) y1 = 0;
        if (y1 > 239) y1 = 239;
      end
      issue(x0, y0, x1, y1, $urandom_range(0, 7), n);
    end
    prev = done_cnt + pending - 1;
    wait_done(prev, dc);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty_end", exp_q.size(), 0);
    chk("pending_end", pending, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
